// File: rtl/pr_if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// One entry layout serves both the main slot and the skid slot.
package pr_if_id_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_entry_t;

  localparam int unsigned ENTRY_W = $bits(if_id_entry_t);

  localparam if_id_entry_t EMPTY_ENTRY = '{
    pc:    '0,
    pc4:   '0,
    instr: NOP_INSTR,
    valid: 1'b0
  };

endpackage

// File: rtl/pr_if_id_slot.sv
// Single IF/ID entry register with clear and load controls; otherwise it holds.
// Clear, including reset, takes priority over load.
module if_id_slot
  import pr_if_id_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= EMPTY_ENTRY;
    end else if (load) begin
      q <= din;
    end
  end

endmodule

// File: rtl/pr_if_id.sv
// IF/ID pipeline register with a one-entry skid buffer.
// The skid buffer catches the fetch that is already in flight when ID stalls.
module pr_if_id
  import pr_if_id_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_if_i,
  input  logic [XLEN-1:0] pc4_if_i,
  input  logic [XLEN-1:0] instr_if_i,
  input  logic            instr_valid_if_i,
  output logic            if_ready_o,
  output logic [XLEN-1:0] pc_id_o,
  output logic [XLEN-1:0] pc4_id_o,
  output logic [XLEN-1:0] instr_id_o,
  output logic            instr_valid_id_o,
  output logic [4:0]      rs1_id_o,
  output logic [4:0]      rs2_id_o,
  output logic [4:0]      rd_id_o
);

  if_id_entry_t m_q;
  if_id_entry_t s_q;
  if_id_entry_t m_din;
  if_id_entry_t incoming;
  logic         m_load;
  logic         m_clear;
  logic         s_load;
  logic         s_clear;
  logic         accept;

  // if_ready_o comes straight from the skid valid flop, so it never depends on stall/flush.
  assign if_ready_o = !s_q.valid;
  assign accept     = instr_valid_if_i && if_ready_o;

  assign incoming = '{
    pc:    pc_if_i,
    pc4:   pc4_if_i,
    instr: instr_if_i,
    valid: 1'b1
  };

  always_comb begin
    m_load  = 1'b0;
    m_clear = flush_i;
    m_din   = incoming;
    s_load  = 1'b0;
    s_clear = flush_i;
    if (!flush_i) begin
      if (!stall_i) begin
        if (s_q.valid) begin
          m_load  = 1'b1;
          m_din   = s_q;
          s_clear = 1'b1;
        end else if (accept) begin
          m_load = 1'b1;
        end else begin
          // Bubble: pc fields keep their last value, instruction becomes a NOP.
          m_load = 1'b1;
          m_din  = '{pc: m_q.pc, pc4: m_q.pc4, instr: NOP_INSTR, valid: 1'b0};
        end
      end else if (accept) begin
        if (m_q.valid) begin
          s_load = 1'b1;
        end else begin
          m_load = 1'b1;
        end
      end
    end
  end

  if_id_slot u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (m_clear),
    .load  (m_load),
    .din   (m_din),
    .q     (m_q)
  );

  if_id_slot u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (s_clear),
    .load  (s_load),
    .din   (incoming),
    .q     (s_q)
  );

  assign pc_id_o          = m_q.pc;
  assign pc4_id_o         = m_q.pc4;
  assign instr_id_o       = m_q.instr;
  assign instr_valid_id_o = m_q.valid;
  assign rs1_id_o         = m_q.instr[19:15];
  assign rs2_id_o         = m_q.instr[24:20];
  assign rd_id_o          = m_q.instr[11:7];

endmodule

// File: tb/tb_pr_if_id.sv
// Directed self-checking bench for pr_if_id: streaming, skid capture,
// bubble fill, flush, flush+stall and reset during a stall.
module tb_pr_if_id;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD_INSTR = 32'h00C5_8533;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_if_i;
  logic [31:0] pc4_if_i;
  logic [31:0] instr_if_i;
  logic        instr_valid_if_i;
  logic        if_ready_o;
  logic [31:0] pc_id_o;
  logic [31:0] pc4_id_o;
  logic [31:0] instr_id_o;
  logic        instr_valid_id_o;
  logic [4:0]  rs1_id_o;
  logic [4:0]  rs2_id_o;
  logic [4:0]  rd_id_o;

  int checks;
  int failures;

  pr_if_id dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .pc_if_i          (pc_if_i),
    .pc4_if_i         (pc4_if_i),
    .instr_if_i       (instr_if_i),
    .instr_valid_if_i (instr_valid_if_i),
    .if_ready_o       (if_ready_o),
    .pc_id_o          (pc_id_o),
    .pc4_id_o         (pc4_id_o),
    .instr_id_o       (instr_id_o),
    .instr_valid_id_o (instr_valid_id_o),
    .rs1_id_o         (rs1_id_o),
    .rs2_id_o         (rs2_id_o),
    .rd_id_o          (rd_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct instruction word per fetch address so misordering is visible.
  function automatic logic [31:0] instrFor(input logic [31:0] pc);
    return {pc[15:0], 16'h0533};
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic v, input logic [31:0] pc);
    rst              = r;
    stall_i          = st;
    flush_i          = fl;
    instr_valid_if_i = v;
    pc_if_i          = pc;
    pc4_if_i         = pc + 32'd4;
    instr_if_i       = instrFor(pc);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic [31:0] exp_pc,
                             input logic [31:0] exp_pc4, input logic [31:0] exp_instr,
                             input logic exp_ready);
    checkEq({tag, ".valid"}, {31'd0, instr_valid_id_o}, {31'd0, exp_valid});
    checkEq({tag, ".pc"}, pc_id_o, exp_pc);
    checkEq({tag, ".pc4"}, pc4_id_o, exp_pc4);
    checkEq({tag, ".instr"}, instr_id_o, exp_instr);
    checkEq({tag, ".ready"}, {31'd0, if_ready_o}, {31'd0, exp_ready});
  endtask

  task automatic checkLive(input string tag, input logic [31:0] pc, input logic exp_ready);
    checkOutput(tag, 1'b1, pc, pc + 32'd4, instrFor(pc), exp_ready);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    stall_i          = 1'b0;
    flush_i          = 1'b0;
    instr_valid_if_i = 1'b0;
    pc_if_i          = '0;
    pc4_if_i         = '0;
    instr_if_i       = '0;
    #2;

    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b1);
    checkEq("reset.rs1", {27'd0, rs1_id_o}, 32'd0);
    checkEq("reset.rs2", {27'd0, rs2_id_o}, 32'd0);
    checkEq("reset.rd", {27'd0, rd_id_o}, 32'd0);

    applyStimulus(0, 0, 0, 1, 32'h00);
    checkLive("stream0", 32'h00, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h04);
    checkLive("stream1", 32'h04, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h08);
    checkLive("stream2", 32'h08, 1'b1);

    applyStimulus(0, 0, 0, 1, 32'h10);
    checkLive("skid.m10", 32'h10, 1'b1);
    applyStimulus(0, 1, 0, 1, 32'h14);
    checkLive("skid.stall1", 32'h10, 1'b0);
    applyStimulus(0, 1, 0, 1, 32'h18);
    checkLive("skid.stall2", 32'h10, 1'b0);
    applyStimulus(0, 0, 0, 1, 32'h18);
    checkLive("skid.drain", 32'h14, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h18);
    checkLive("skid.resume", 32'h18, 1'b1);

    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("bubble", 1'b0, 32'h18, 32'h1C, NOP, 1'b1);
    applyStimulus(0, 1, 0, 1, 32'h20);
    checkLive("fill.m20", 32'h20, 1'b1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("fill.after", 1'b0, 32'h20, 32'h24, NOP, 1'b1);

    applyStimulus(0, 0, 0, 1, 32'h30);
    checkLive("flush.m30", 32'h30, 1'b1);
    applyStimulus(0, 1, 0, 1, 32'h34);
    checkLive("flush.s34", 32'h30, 1'b0);
    applyStimulus(0, 0, 1, 1, 32'h38);
    checkOutput("flush", 1'b0, 32'h0, 32'h0, NOP, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h100);
    checkLive("flush.refetch", 32'h100, 1'b1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("flush.idle", 1'b0, 32'h100, 32'h104, NOP, 1'b1);

    applyStimulus(0, 0, 0, 1, 32'h40);
    checkLive("fs.m40", 32'h40, 1'b1);
    applyStimulus(0, 1, 0, 1, 32'h44);
    checkLive("fs.s44", 32'h40, 1'b0);
    applyStimulus(0, 1, 1, 1, 32'h48);
    checkOutput("fs.flush", 1'b0, 32'h0, 32'h0, NOP, 1'b1);
    applyStimulus(0, 1, 0, 1, 32'h4C);
    checkLive("fs.fill", 32'h4C, 1'b1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("fs.idle", 1'b0, 32'h4C, 32'h50, NOP, 1'b1);

    applyStimulus(0, 0, 0, 1, 32'h50);
    checkLive("rst.m50", 32'h50, 1'b1);
    applyStimulus(0, 1, 0, 1, 32'h54);
    checkLive("rst.s54", 32'h50, 1'b0);
    applyStimulus(1, 1, 0, 1, 32'h58);
    checkOutput("rst.mid", 1'b0, 32'h0, 32'h0, NOP, 1'b1);

    rst              = 1'b0;
    stall_i          = 1'b0;
    flush_i          = 1'b0;
    instr_valid_if_i = 1'b1;
    pc_if_i          = 32'h0;
    pc4_if_i         = 32'h4;
    instr_if_i       = ADD_INSTR;
    @(posedge clk);
    #1;
    checkOutput("rst.first", 1'b1, 32'h0, 32'h4, ADD_INSTR, 1'b1);
    checkEq("rst.first.rs1", {27'd0, rs1_id_o}, 32'd11);
    checkEq("rst.first.rs2", {27'd0, rs2_id_o}, 32'd12);
    checkEq("rst.first.rd", {27'd0, rd_id_o}, 32'd10);

    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("end.idle", 1'b0, 32'h0, 32'h4, NOP, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
